// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
package mem_resp_pkg;

   localparam int DEPTH_LOG2_DEF = 8;
   localparam int READ_LAT_DEF   = 2;
   localparam logic [15:0] OOR_DATA = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_DRIVE,
      WRITE
   } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Two byte lanes of storage with per-lane write enables and a registered read port.
module mem_resp_array #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk_i,
   input  logic [1:0]            we_i,
   input  logic [DEPTH_LOG2-1:0] wr_addr_i,
   input  logic [15:0]           wr_data_i,
   input  logic [DEPTH_LOG2-1:0] rd_addr_i,
   output logic [15:0]           rd_data_o
);

   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem_q [0:(1 << DEPTH_LOG2) - 1];
      logic [7:0] rd_q;

      always_ff @(posedge clk_i) begin
         if (we_i[gi]) begin
            mem_q[wr_addr_i] <= wr_data_i[gi*8 +: 8];
         end
         rd_q <= mem_q[rd_addr_i];
      end

      assign rd_data_o[gi*8 +: 8] = rd_q;
   end

endmodule

// File: rtl/mem_responder.sv
// Synchronous SRAM-style responder: strobe-driven reads/writes on a shared
// tri-state bus plus a side preload port usable while the chip is deselected.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int READ_LAT   = READ_LAT_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  CE,
   input  logic                  OE,
   input  logic                  WE,
   input  logic                  UB,
   input  logic                  LB,
   input  logic [19:0]           ADDR,
   inout  wire  [15:0]           Data,
   input  logic                  load_valid,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [15:0]           load_data,
   output logic                  load_ready
);

   state_e                state_q;
   logic [2:0]            cnt_q;
   logic [19:0]           addr_q;
   logic                  ub_q;
   logic                  lb_q;
   logic                  drive_en_q;
   logic                  load_ready_q;

   logic                  strobe_wr;
   logic                  in_oor;
   logic                  load_acc;
   logic                  relatch;
   logic [1:0]            we;
   logic [DEPTH_LOG2-1:0] wr_addr;
   logic [DEPTH_LOG2-1:0] rd_addr;
   logic [15:0]           wr_data;
   logic [15:0]           rd_data;
   logic [15:0]           dout;

   assign strobe_wr = !CE && !WE;
   assign in_oor    = |ADDR[19:DEPTH_LOG2];
   // A load only lands on an edge that also sees CE high, so a strobe access
   // arriving on the same edge always takes the write port.
   assign load_acc  = load_ready_q && load_valid && CE;
   assign relatch   = !CE && !OE && WE &&
                      (state_q == IDLE || state_q == WRITE || ADDR != addr_q);

   assign we      = strobe_wr ? ({2{!in_oor}} & ~{UB, LB}) : {2{load_acc}};
   assign wr_addr = strobe_wr ? ADDR[DEPTH_LOG2-1:0] : load_addr;
   assign wr_data = strobe_wr ? Data : load_data;
   // Read address runs one step ahead so the word is ready even at READ_LAT=1.
   assign rd_addr = relatch ? ADDR[DEPTH_LOG2-1:0] : addr_q[DEPTH_LOG2-1:0];

   mem_resp_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk_i     (Clk),
      .we_i      (we),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         addr_q       <= 20'd0;
         ub_q         <= 1'b1;
         lb_q         <= 1'b1;
         drive_en_q   <= 1'b0;
         load_ready_q <= 1'b0;
      end else begin
         ub_q         <= UB;
         lb_q         <= LB;
         load_ready_q <= CE;
         drive_en_q   <= 1'b0;
         if (strobe_wr) begin
            state_q <= WRITE;
         end else if (CE || OE) begin
            state_q <= IDLE;
         end else if (relatch) begin
            state_q <= RD_WAIT;
            addr_q  <= ADDR;
            cnt_q   <= 3'(READ_LAT - 1);
         end else if (state_q == RD_WAIT) begin
            if (cnt_q == 3'd0) begin
               state_q    <= RD_DRIVE;
               drive_en_q <= !(UB && LB);
            end else begin
               cnt_q <= cnt_q - 3'd1;
            end
         end else begin
            drive_en_q <= !(UB && LB);
         end
      end
   end

   always_comb begin
      dout = (|addr_q[19:DEPTH_LOG2]) ? OOR_DATA : rd_data;
      if (ub_q) dout[15:8] = 8'h00;
      if (lb_q) dout[7:0]  = 8'h00;
   end

   assign Data       = drive_en_q ? dout : {16{1'bz}};
   assign load_ready = load_ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; an undriven bus reads back as 16'hFFFF via pull-ups.
module tb_mem_responder;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        CE, OE, WE, UB, LB;
   logic [19:0] ADDR;
   wire  [15:0] Data;
   logic        load_valid;
   logic [7:0]  load_addr;
   logic [15:0] load_data;
   logic        load_ready;
   logic        tb_drv;
   logic [15:0] tb_data;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] d0, d1, d2;

   always #5 Clk = ~Clk;

   assign Data = tb_drv ? tb_data : {16{1'bz}};
   for (genvar gi = 0; gi < 16; gi++) begin : g_pu
      pullup (Data[gi]);
   end

   mem_responder dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .CE         (CE),
      .OE         (OE),
      .WE         (WE),
      .UB         (UB),
      .LB         (LB),
      .ADDR       (ADDR),
      .Data       (Data),
      .load_valid (load_valid),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_ready (load_ready)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic go_idle();
      CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1; tb_drv = 1'b0;
      tick();
   endtask

   task automatic write_word(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
      CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = ub; LB = lb; ADDR = a;
      tb_drv = 1'b1; tb_data = d;
      tick();
      $display("wr %05h ub=%b lb=%b data=%04h", a, ub, lb, d);
   endtask

   // Returns the bus one, two and three edges after the strobe is first sampled.
   task automatic read_word(input logic [19:0] a, input logic ub, input logic lb,
                            output logic [15:0] r0, output logic [15:0] r1, output logic [15:0] r2);
      CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = ub; LB = lb; ADDR = a; tb_drv = 1'b0;
      tick(); r0 = Data;
      tick(); r1 = Data;
      tick(); r2 = Data;
      $display("rd %05h ub=%b lb=%b -> %04h", a, ub, lb, r2);
   endtask

   task automatic test_reset();
      #2 Reset = 1'b0;
      #1;
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", load_ready); end
      n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL reset_bus: got %h want ffff", Data); end
      tick();
      Reset = 1'b1;
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_held: got %b want 0", load_ready); end
      tick();
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", load_ready); end
   endtask

   task automatic test_preload();
      load_valid = 1'b1; load_addr = 8'h14; load_data = 16'hACAC;
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL preload_ready: got %b want 1", load_ready); end
      tick();
      load_valid = 1'b0;
      $display("load %02h data=%04h", 8'h14, 16'hACAC);
      read_word(20'h00014, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d0 !== 16'hFFFF) begin n_err++; $display("FAIL preload_lat0: got %h want ffff", d0); end
      n_cmp++; if (d1 !== 16'hFFFF) begin n_err++; $display("FAIL preload_lat1: got %h want ffff", d1); end
      n_cmp++; if (d2 !== 16'hACAC) begin n_err++; $display("FAIL preload_data: got %h want acac", d2); end
      go_idle();
      n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL preload_release: got %h want ffff", Data); end
   endtask

   task automatic test_byte_write();
      write_word(20'h00020, 16'hFFFF, 1'b0, 1'b0);
      write_word(20'h00020, 16'h1234, 1'b0, 1'b1);
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL write_ready: got %b want 0", load_ready); end
      go_idle();
      read_word(20'h00020, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d2 !== 16'h12FF) begin n_err++; $display("FAIL byte_merge: got %h want 12ff", d2); end
      go_idle();
      read_word(20'h00020, 1'b1, 1'b0, d0, d1, d2);
      n_cmp++; if (d1 !== 16'hFFFF) begin n_err++; $display("FAIL lb_lat1: got %h want ffff", d1); end
      n_cmp++; if (d2 !== 16'h00FF) begin n_err++; $display("FAIL lb_only: got %h want 00ff", d2); end
      go_idle();
   endtask

   task automatic test_out_of_range();
      write_word(20'h10020, 16'hBEEF, 1'b0, 1'b0);
      go_idle();
      read_word(20'h00020, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d2 !== 16'h12FF) begin n_err++; $display("FAIL oor_no_write: got %h want 12ff", d2); end
      go_idle();
      read_word(20'h10020, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d1 !== 16'hFFFF) begin n_err++; $display("FAIL oor_lat1: got %h want ffff", d1); end
      n_cmp++; if (d2 !== 16'h0000) begin n_err++; $display("FAIL oor_read: got %h want 0000", d2); end
      go_idle();
   endtask

   task automatic test_contention();
      CE = 1'b0; OE = 1'b0; WE = 1'b0; UB = 1'b0; LB = 1'b0; ADDR = 20'h00030; tb_drv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL contention_bus%0d: got %h want ffff", i, Data); end
      end
      tb_drv = 1'b1; tb_data = 16'h5A3C;
      tick();
      $display("wr %05h oe=0 we=0 data=%04h", 20'h00030, 16'h5A3C);
      go_idle();
      read_word(20'h00030, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d2 !== 16'h5A3C) begin n_err++; $display("FAIL contention_write: got %h want 5a3c", d2); end
      go_idle();
   endtask

   task automatic test_back_to_back();
      read_word(20'h00014, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d2 !== 16'hACAC) begin n_err++; $display("FAIL b2b_first: got %h want acac", d2); end
      ADDR = 20'h00020;
      tick();
      n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL b2b_release: got %h want ffff", Data); end
      tick();
      n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL b2b_wait: got %h want ffff", Data); end
      tick();
      n_cmp++; if (Data !== 16'h12FF) begin n_err++; $display("FAIL b2b_second: got %h want 12ff", Data); end
      $display("rd %05h (addr change) -> %04h", 20'h00020, Data);
      CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = 1'b0; LB = 1'b0; ADDR = 20'h00050;
      tick();
      n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL write_release: got %h want ffff", Data); end
      write_word(20'h00050, 16'h1111, 1'b0, 1'b0);
      read_word(20'h00050, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d0 !== 16'hFFFF) begin n_err++; $display("FAIL raw_lat0: got %h want ffff", d0); end
      n_cmp++; if (d2 !== 16'h1111) begin n_err++; $display("FAIL raw_data: got %h want 1111", d2); end
      go_idle();
   endtask

   task automatic test_reset_mid_read();
      read_word(20'h00014, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d2 !== 16'hACAC) begin n_err++; $display("FAIL rst_pre: got %h want acac", d2); end
      #2 Reset = 1'b0;
      #1;
      n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL rst_async_bus: got %h want ffff", Data); end
      n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_async_ready: got %b want 0", load_ready); end
      tick();
      Reset = 1'b1;
      tick();
      n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL rst_idle0: got %h want ffff", Data); end
      tick();
      n_cmp++; if (Data !== 16'hFFFF) begin n_err++; $display("FAIL rst_idle1: got %h want ffff", Data); end
      tick();
      n_cmp++; if (Data !== 16'hACAC) begin n_err++; $display("FAIL rst_reread: got %h want acac", Data); end
      $display("rd %05h after reset -> %04h", 20'h00014, Data);
      go_idle();
   endtask

   task automatic test_load_conflict();
      load_valid = 1'b1; load_addr = 8'h40; load_data = 16'h7E81;
      CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = 1'b0; LB = 1'b0; ADDR = 20'h00014;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL conflict_ready%0d: got %b want 0", i, load_ready); end
      end
      n_cmp++; if (Data !== 16'hACAC) begin n_err++; $display("FAIL conflict_read: got %h want acac", Data); end
      go_idle();
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL conflict_ready_idle: got %b want 1", load_ready); end
      tick();
      load_valid = 1'b0;
      $display("load %02h data=%04h", 8'h40, 16'h7E81);
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL conflict_ready_after: got %b want 1", load_ready); end
      read_word(20'h00040, 1'b0, 1'b0, d0, d1, d2);
      n_cmp++; if (d2 !== 16'h7E81) begin n_err++; $display("FAIL conflict_load_data: got %h want 7e81", d2); end
      go_idle();
   endtask

   initial begin
      Reset = 1'b1;
      CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1; ADDR = 20'd0;
      load_valid = 1'b0; load_addr = 8'd0; load_data = 16'd0;
      tb_drv = 1'b0; tb_data = 16'd0;
      test_reset();
      test_preload();
      test_byte_write();
      test_out_of_range();
      test_contention();
      test_back_to_back();
      test_reset_mid_read();
      test_load_conflict();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
